// File: rtl/fft_stage_ctrl.sv
// rtl/fft_stage_ctrl.sv - radix-2 DIT FFT stage/butterfly sequencer
// Walks LOGN stages of N/2 butterflies, flushing the BF_LAT-deep datapath between stages.
module fft_stage_ctrl #(
  parameter int N      = 8,
  parameter int LOGN   = 3,
  parameter int BF_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stall,
  output logic            busy,
  output logic            done,
  output logic            bf_valid,
  output logic [LOGN-1:0] stage,
  output logic [LOGN-2:0] bfly,
  output logic [LOGN-2:0] tw_addr,
  output logic [LOGN-1:0] addr_a,
  output logic [LOGN-1:0] addr_b
);

  localparam int CW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
  localparam logic [CW-1:0]   CNT_LAST   = CW'(BF_LAT - 1);
  localparam logic [LOGN-2:0] BFLY_LAST  = (LOGN-1)'(N / 2 - 1);
  localparam logic [LOGN-1:0] STAGE_LAST = LOGN'(LOGN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [LOGN-1:0] stage_q, stage_d;
  logic [LOGN-2:0] bfly_q, bfly_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            bf_valid_q, bf_valid_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      stage_q    <= '0;
      bfly_q     <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bf_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      bfly_q     <= bfly_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bf_valid_q <= bf_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    bfly_d     = bfly_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bf_valid_d = bf_valid_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          busy_d     = 1'b1;
          bf_valid_d = 1'b1;
          stage_d    = '0;
          bfly_d     = '0;
        end
      end
      RUN: begin
        // a stalled issue simply holds every issue output
        if (!stall) begin
          if (bfly_q == BFLY_LAST) begin
            state_d    = FLUSH;
            bf_valid_d = 1'b0;
            cnt_d      = '0;
          end else begin
            bfly_d = bfly_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (cnt_q == CNT_LAST) begin
          if (stage_q == STAGE_LAST) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d    = RUN;
            stage_d    = stage_q + 1'b1;
            bfly_d     = '0;
            bf_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic [LOGN-1:0] bfly_w, span, pos, grp, a_w;

  // pos/grp split of the butterfly index; all arithmetic fits in LOGN bits
  always_comb begin
    bfly_w = {1'b0, bfly_q};
    span   = LOGN'(1) << stage_q;
    pos    = bfly_w & (span - 1'b1);
    grp    = bfly_w >> stage_q;
    a_w    = (grp << (stage_q + 1'b1)) + pos;
  end

  assign tw_addr  = (LOGN-1)'(pos << (STAGE_LAST - stage_q));
  assign addr_a   = a_w;
  assign addr_b   = a_w + span;

  assign busy     = busy_q;
  assign done     = done_q;
  assign bf_valid = bf_valid_q;
  assign stage    = stage_q;
  assign bfly     = bfly_q;

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// tb/tb_fft_stage_ctrl.sv - self-checking bench for fft_stage_ctrl
// Expected issue order comes from a stage/butterfly queue built with plain arithmetic.
module tb_fft_stage_ctrl;
  localparam int N = 8, LOGN = 3, BF_LAT = 2;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, stall = 1'b0;
  logic busy, done, bf_valid;
  logic [LOGN-1:0] stage, addr_a, addr_b;
  logic [LOGN-2:0] bfly, tw_addr;

  fft_stage_ctrl #(.N(N), .LOGN(LOGN), .BF_LAT(BF_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .busy(busy), .done(done), .bf_valid(bf_valid),
    .stage(stage), .bfly(bfly), .tw_addr(tw_addr),
    .addr_a(addr_a), .addr_b(addr_b)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int eq_stage[$], eq_bfly[$], eq_tw[$], eq_a[$], eq_b[$];
  int iss_tw[64], iss_a[64], iss_b[64];
  int rec_valid[64], rec_stage[64], rec_bfly[64];

  function automatic void build_expected();
    eq_stage.delete(); eq_bfly.delete(); eq_tw.delete(); eq_a.delete(); eq_b.delete();
    for (int s = 0; s < LOGN; s++) begin
      for (int b = 0; b < N / 2; b++) begin
        int span = 2 ** s;
        int pos  = b % span;
        int grp  = b / span;
        eq_stage.push_back(s);
        eq_bfly.push_back(b);
        eq_tw.push_back(pos * (N / (2 * span)));
        eq_a.push_back(grp * 2 * span + pos);
        eq_b.push_back(grp * 2 * span + pos + span);
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: random stall at pct; 1: three stalls at stage 0 bfly 2; 2: stall throughout FLUSH
  task automatic run_one(input int mode, input int pct, input bit hold, output int done_cyc);
    int cyc = 1, busy_cnt = 0, run_stalls = 0, n_iss = 0, stall_left = 3;
    build_expected();
    foreach (rec_valid[i]) begin rec_valid[i] = -1; rec_stage[i] = -1; rec_bfly[i] = -1; end
    done_cyc = -1;
    start = 1'b1;
    stall = 1'b0;
    step();
    if (!hold) start = 1'b0;
    while (cyc < 2000) begin
      if (cyc < 64) begin
        rec_valid[cyc] = int'(bf_valid); rec_stage[cyc] = int'(stage); rec_bfly[cyc] = int'(bfly);
      end
      case (mode)
        0: stall = ($urandom_range(99) < pct);
        1: begin
          stall = bf_valid && stage == 0 && bfly == 2 && stall_left > 0;
          if (stall) stall_left--;
        end
        default: stall = busy && !bf_valid;
      endcase
      if (done) begin
        check_eq("busy_in_done", int'(busy), 0);
        done_cyc = cyc;
        break;
      end
      if (busy) busy_cnt++;
      if (bf_valid) begin
        if (stall) run_stalls++;
        else if (eq_stage.size() == 0) check_eq("extra_issue", 1, 0);
        else begin
          check_eq("iss_stage", int'(stage), eq_stage.pop_front());
          check_eq("iss_bfly", int'(bfly), eq_bfly.pop_front());
          check_eq("iss_tw", int'(tw_addr), eq_tw.pop_front());
          check_eq("iss_addr_a", int'(addr_a), eq_a.pop_front());
          check_eq("iss_addr_b", int'(addr_b), eq_b.pop_front());
          if (n_iss < 64) begin
            iss_tw[n_iss] = int'(tw_addr); iss_a[n_iss] = int'(addr_a); iss_b[n_iss] = int'(addr_b);
          end
          n_iss++;
        end
      end
      step();
      cyc++;
    end
    stall = 1'b0;
    check_eq("done_seen", int'(done_cyc >= 0), 1);
    check_eq("issues_left", eq_stage.size(), 0);
    check_eq("busy_cycles", busy_cnt, LOGN * (N / 2 + BF_LAT) + run_stalls);
    step();
    check_eq("done_one_cycle", int'(done), 0);
    check_eq("idle_after_done", int'(busy), 0);
  endtask

  int dc;
  bit saw_done;

  initial begin
    rst = 1'b0;
    repeat (2) step();
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_valid", int'(bf_valid), 0);
    check_eq("rst_stage", int'(stage), 0);
    check_eq("rst_bfly", int'(bfly), 0);
    check_eq("rst_tw", int'(tw_addr), 0);
    check_eq("rst_addr_a", int'(addr_a), 0);
    check_eq("rst_addr_b", int'(addr_b), 1);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) step();
    check_eq("idle_no_start", int'(busy), 0);

    // nominal run
    run_one(0, 0, 1'b0, dc);
    check_eq("nom_done_cycle", dc, 19);
    check_eq("nom_valid_c1", rec_valid[1], 1);
    check_eq("nom_valid_c4", rec_valid[4], 1);
    check_eq("nom_flush_c5", rec_valid[5], 0);
    check_eq("nom_flush_c6", rec_valid[6], 0);
    check_eq("nom_run_c7", rec_valid[7], 1);
    check_eq("nom_stage_c7", rec_stage[7], 1);
    check_eq("nom_flush_c18", rec_valid[18], 0);
    begin
      int exp_tw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
      for (int i = 0; i < 12; i++) check_eq($sformatf("nom_tw_%0d", i), iss_tw[i], exp_tw[i]);
    end
    check_eq("s1b3_addr_a", iss_a[7], 5);
    check_eq("s1b3_addr_b", iss_b[7], 7);
    check_eq("s2b1_addr_a", iss_a[9], 1);
    check_eq("s2b1_addr_b", iss_b[9], 5);

    // three stall cycles at stage 0 bfly 2
    run_one(1, 0, 1'b0, dc);
    check_eq("stall_done_cycle", dc, 22);
    for (int c = 3; c <= 6; c++) begin
      check_eq($sformatf("stall_bfly_c%0d", c), rec_bfly[c], 2);
      check_eq($sformatf("stall_valid_c%0d", c), rec_valid[c], 1);
    end

    // stall during FLUSH is ignored
    run_one(2, 0, 1'b0, dc);
    check_eq("fstall_done_cycle", dc, 19);
    check_eq("fstall_stage_c7", rec_stage[7], 1);
    check_eq("fstall_valid_c7", rec_valid[7], 1);

    // start held through a whole run
    run_one(0, 0, 1'b1, dc);
    check_eq("hold_done_cycle", dc, 19);
    step();
    check_eq("hold_rerun_busy", int'(busy), 1);
    check_eq("hold_rerun_stage", int'(stage), 0);
    check_eq("hold_rerun_bfly", int'(bfly), 0);
    start = 1'b0;

    // asynchronous reset during a later FLUSH
    saw_done = 1'b0;
    while (!(busy && !bf_valid && stage == 1)) begin
      step();
      if (done) saw_done = 1'b1;
      if (stage > 1) break;
    end
    check_eq("mid_reach_flush", int'(stage), 1);
    #2 rst = 1'b0;
    #1;
    check_eq("mid_rst_busy", int'(busy), 0);
    check_eq("mid_rst_valid", int'(bf_valid), 0);
    check_eq("mid_rst_stage", int'(stage), 0);
    check_eq("mid_rst_addr_b", int'(addr_b), 1);
    repeat (3) begin step(); if (done) saw_done = 1'b1; end
    @(negedge clk);
    rst = 1'b1;
    repeat (4) begin step(); if (done) saw_done = 1'b1; end
    check_eq("mid_no_done", int'(saw_done), 0);
    check_eq("mid_stay_idle", int'(busy), 0);

    // randomised stall runs
    for (int r = 0; r < 6; r++) run_one(0, 20 + 10 * r, 1'b0, dc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
